mac_array_ctrl: RTL

//  Sequencer for an N x N systolic array of 8b int MAC cells computing C = A*B with inner length K.

---
 rtl/mac_pkg.sv | 25 ++
 rtl/mac_array_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Brief    : Shared types and timing constants for the MAC array sequencer.
// Revision : 1.0
// ============================================================================
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int MAC_LAT = 3;

  // Skew across both array edges plus the load/mult/acc pipeline.
  function automatic int DRAIN_LEN(input int n);
    return 2 * (n - 1) + MAC_LAT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_array_ctrl
// Brief    : Sequencer for an N x N systolic MAC array: clear, stream K, drain.
// Revision : 1.0
// ============================================================================
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K_W-1:0] k_len,
  input  logic           hold,
  output logic           busy,
  output logic           done,
  output logic           mac_clear,
  output logic           load_en,
  output logic           mult_en,
  output logic           acc_en,
  output logic           rd_en,
  output logic [K_W-1:0] rd_idx,
  output logic           zero_pad
);

  localparam int C_DRAIN_LEN = DRAIN_LEN(N);
  localparam int C_DCNT_W    = $clog2(C_DRAIN_LEN + 1);

  state_t              r_state;
  logic [K_W-1:0]      r_k_len;
  logic [K_W-1:0]      r_rd_idx;
  logic [C_DCNT_W-1:0] r_drain_cnt;
  logic                r_done;
  logic                r_clear;
  logic                r_zero_pad;

  logic                w_active;
  logic                w_last_idx;
  logic                w_last_drain;

  assign w_active     = ((r_state == ST_STREAM) || (r_state == ST_DRAIN)) && !hold;
  assign w_last_idx   = (r_rd_idx == (r_k_len - K_W'(1)));
  assign w_last_drain = (r_drain_cnt == C_DCNT_W'(C_DRAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k_len     <= '0;
      r_rd_idx    <= '0;
      r_drain_cnt <= '0;
      r_done      <= 1'b0;
      r_clear     <= 1'b0;
      r_zero_pad  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_k_len <= k_len;
            r_clear <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_rd_idx <= '0;
          if (r_k_len == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (!hold) begin
            if (w_last_idx) begin
              r_rd_idx    <= '0;
              r_drain_cnt <= '0;
              r_zero_pad  <= 1'b1;
              r_state     <= ST_DRAIN;
            end else begin
              r_rd_idx <= r_rd_idx + K_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!hold) begin
            if (w_last_drain) begin
              r_zero_pad <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_drain_cnt <= r_drain_cnt + C_DCNT_W'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Enables follow hold combinationally so a stall freezes every array register.
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign mac_clear = r_clear;
  assign load_en   = w_active;
  assign mult_en   = w_active;
  assign acc_en    = w_active;
  assign rd_en     = w_active && (r_state == ST_STREAM);
  assign rd_idx    = r_rd_idx;
  assign zero_pad  = r_zero_pad;

endmodule
`default_nettype wire
